// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD read and write paths.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package lcd_pkg;

  // Bus-read request kinds; encoding 2'b11 is reserved and decodes as status.
  typedef enum logic [1:0] {
    RD_STATUS = 2'd0,
    RD_DATA   = 2'd1,
    RD_POLL   = 2'd2
  } lcd_rd_kind_t;

  // Read-side sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_EN_HIGH = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RESP    = 3'd5
  } lcd_rd_state_t;

  // Default bus timing in 50 MHz clock cycles (20 ns each).
  localparam int LCD_T_AS     = 3;    // RS/RW setup before EN rises: 60 ns
  localparam int LCD_T_EH     = 15;   // EN high width: 300 ns
  localparam int LCD_T_EL     = 15;   // EN low / hold before next access: 300 ns
  localparam int LCD_POLL_MAX = 4095; // status reads allowed per busy poll

  // Width of the shared phase timer; every phase length must fit in it.
  localparam int LCD_TMR_W = 8;

  // Map a raw request code onto a legal kind; the reserved code becomes status.
  function automatic lcd_rd_kind_t lcd_decode_kind(input logic [1:0] code);
    lcd_rd_kind_t k;
    case (code)
      2'd1:    k = RD_DATA;
      2'd2:    k = RD_POLL;
      default: k = RD_STATUS;
    endcase
    return k;
  endfunction

  // The busy flag lives in bit 7 of the status byte.
  function automatic logic lcd_bf(input logic [7:0] status_byte);
    return status_byte[7];
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one bus phase; done while the count is zero.
// Latency: done rises load_val cycles after the load cycle.
// Backpressure: none; a load always overrides the running count.
module lcd_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count down to zero and park there until the next phase reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 bus read controller: status read, data read, or busy-flag poll.
// Latency: 2+T_AS+T_EH+T_EL cycles from accept to resp_valid, plus T_AS+T_EH+T_EL per extra poll read.
// Backpressure: req_ready only in IDLE; waits on bus_grant; responses cannot be stalled.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = LCD_T_AS,
  parameter int T_EH     = LCD_T_EH,
  parameter int T_EL     = LCD_T_EL,
  parameter int POLL_MAX = LCD_POLL_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_busy,
  output logic       resp_timeout,
  output logic       bus_req,
  input  logic       bus_grant,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int PC_W = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);

  localparam logic [LCD_TMR_W-1:0] LD_AS = LCD_TMR_W'(T_AS - 1);
  localparam logic [LCD_TMR_W-1:0] LD_EH = LCD_TMR_W'(T_EH - 1);
  localparam logic [LCD_TMR_W-1:0] LD_EL = LCD_TMR_W'(T_EL - 1);

  lcd_rd_state_t        state;
  lcd_rd_kind_t         kind_q;
  logic [PC_W-1:0]      poll_cnt;
  logic [7:0]           rd_byte;

  logic                 tmr_load;
  logic [LCD_TMR_W-1:0] tmr_val;
  logic                 tmr_done;

  logic                 poll_more;
  logic                 repoll;
  logic                 accept;

  // Requests are taken only in IDLE; reset masks ready so a coincident request is dropped.
  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Another status read is allowed while the next read count stays below POLL_MAX.
  assign poll_more = (int'(poll_cnt) + 1) < POLL_MAX;
  assign repoll    = (kind_q == RD_POLL) && lcd_bf(rd_byte) && poll_more;

  // Reload the shared phase timer on every transition into SETUP, EN_HIGH or HOLD.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_ARB: begin
        if (bus_grant) begin
          tmr_load = 1'b1;
          tmr_val  = LD_AS;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = LD_EH;
        end
      end
      ST_EN_HIGH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = LD_EL;
        end
      end
      ST_HOLD: begin
        if (tmr_done && repoll) begin
          tmr_load = 1'b1;
          tmr_val  = LD_AS;
        end
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  lcd_phase_timer #(
    .W(LCD_TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Read-cycle sequencer; bus controls and response fields are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      kind_q       <= RD_STATUS;
      poll_cnt     <= '0;
      rd_byte      <= 8'h00;
      resp_valid   <= 1'b0;
      resp_data    <= 8'h00;
      resp_busy    <= 1'b0;
      resp_timeout <= 1'b0;
      bus_req      <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_rw       <= 1'b0;
      lcd_en       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            kind_q   <= lcd_decode_kind(req_kind);
            poll_cnt <= '0;
            bus_req  <= 1'b1;
            state    <= ST_ARB;
          end
        end
        ST_ARB: begin
          // Grant is sampled only here; the arbiter keeps it while bus_req stays high.
          if (bus_grant) begin
            lcd_rw <= 1'b1;
            lcd_rs <= (kind_q == RD_DATA);
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            lcd_en <= 1'b1;
            state  <= ST_EN_HIGH;
          end
        end
        ST_EN_HIGH: begin
          // Capture on the last EN-high cycle, when the LCD output has settled longest.
          if (tmr_done) begin
            rd_byte <= lcd_data_in;
            lcd_en  <= 1'b0;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            if (repoll) begin
              // Keep the bus and RS/RW; go straight back to setup for another status read.
              poll_cnt <= poll_cnt + 1'b1;
              state    <= ST_SETUP;
            end else begin
              resp_valid   <= 1'b1;
              resp_data    <= rd_byte;
              resp_busy    <= (kind_q != RD_DATA) && lcd_bf(rd_byte);
              resp_timeout <= (kind_q == RD_POLL) && lcd_bf(rd_byte);
              bus_req      <= 1'b0;
              lcd_rs       <= 1'b0;
              lcd_rw       <= 1'b0;
              state        <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader with a behavioural LCD bus and arbiter.
// Latency: expected response cycles are hand-computed per request.
// Backpressure: arbiter grant can be tied high or delayed.
module tb_lcd_bus_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_kind;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_busy;
  logic       resp_timeout;
  logic       bus_req;
  logic       bus_grant;
  logic [7:0] lcd_data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  lcd_bus_reader #(
    .POLL_MAX(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_busy    (resp_busy),
    .resp_timeout (resp_timeout),
    .bus_req      (bus_req),
    .bus_grant    (bus_grant),
    .lcd_data_in  (lcd_data_in),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       b;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rd_vals[$];
  logic [7:0] stuck_val = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_pulses = 0;
  int resp_seen = 0;
  int en_len = 0;
  int age = 0;
  bit en_prev = 1'b0;
  bit rsrw_ok = 1'b1;
  bit exp_rs = 1'b0;
  bit en_skip = 1'b0;
  bit grant_delay = 1'b0;
  bit gnt_held = 1'b0;
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Arbiter model: tied-high grant, or grant 10 cycles after bus_req first appears.
  always @(negedge clk) begin
    if (!grant_delay) begin
      bus_grant = 1'b1;
      age = 0;
    end else if (!bus_req) begin
      bus_grant = 1'b0;
      age = 0;
    end else begin
      if (age < 11) age++;
      bus_grant = (age >= 11);
    end
  end

  // Bus protocol guards: grant held while requested, EN low while waiting in ARB.
  always @(negedge clk) begin
    if (gnt_held && bus_req && !bus_grant) begin
      fails++;
      $display("FAIL grant_dropped: bus_grant 0 while bus_req 1, required 1");
    end
    gnt_held = bus_req && bus_grant;
    if (bus_req && !bus_grant && lcd_en) begin
      fails++;
      $display("FAIL en_in_arb: lcd_en 1 before grant, required 0");
    end
  end

  // LCD model: on each EN rise present the next byte; check pulse width and RS/RW.
  always @(negedge clk) begin
    if (lcd_en) begin
      if (!en_prev) begin
        en_pulses++;
        lcd_data_in = (rd_vals.size() != 0) ? rd_vals.pop_front() : stuck_val;
        en_len = 0;
        rsrw_ok = 1'b1;
      end
      en_len++;
      if (lcd_rw !== 1'b1 || lcd_rs !== exp_rs) rsrw_ok = 1'b0;
    end else if (en_prev && !en_skip) begin
      chk("en_high_len", en_len, 15);
      chk("rs_rw_during_en", rsrw_ok, 1);
    end
    en_prev = lcd_en;
  end

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: resp_valid at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.t);
        chk("resp_data", resp_data, e.d);
        chk("resp_busy", resp_busy, e.b);
        chk("resp_timeout", resp_timeout, e.to);
        chk("rw_in_resp", lcd_rw, 0);
      end
    end
  end

  task automatic run_read(input logic [1:0] kind, input bit rs, input int lat,
                          input logic [7:0] d, input bit b, input bit to,
                          input int pulses, input bit delayed);
    int t0;
    bit done;
    @(negedge clk);
    en_pulses   = 0;
    exp_rs      = rs;
    grant_delay = delayed;
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_kind  = kind;
    t0 = cyc;
    sb.push_back('{t: t0 + lat, d: d, b: b, to: to});
    @(negedge clk);
    req_valid = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (req_ready && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      chk("resp_wait_timeout", 0, 1);
      sb.delete();
    end else begin
      chk("ready_back_cycle", cyc - t0, lat + 1);
    end
    chk("en_pulse_count", en_pulses, pulses);
    grant_delay = 1'b0;
  endtask

  initial begin
    int seen0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_kind    = 2'd0;
    lcd_data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_resp_busy", resp_busy, 0);
    chk("rst_resp_timeout", resp_timeout, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_lcd_ctl", {lcd_rs, lcd_rw, lcd_en}, 3'b000);
    // Reset beats a coincident request.
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_no_accept_bus_req", bus_req, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", req_ready, 1);

    // Status read, grant tied high.
    rd_vals.push_back(8'h25);
    run_read(2'd0, 1'b0, 35, 8'h25, 1'b0, 1'b0, 1, 1'b0);
    // Data reads: RS high, busy forced 0 even with bit 7 set.
    rd_vals.push_back(8'h41);
    run_read(2'd1, 1'b1, 35, 8'h41, 1'b0, 1'b0, 1, 1'b0);
    rd_vals.push_back(8'hC1);
    run_read(2'd1, 1'b1, 35, 8'hC1, 1'b0, 1'b0, 1, 1'b0);
    // Status read reporting busy; reserved kind behaves as status.
    rd_vals.push_back(8'hA5);
    run_read(2'd0, 1'b0, 35, 8'hA5, 1'b1, 1'b0, 1, 1'b0);
    rd_vals.push_back(8'h83);
    run_read(2'd3, 1'b0, 35, 8'h83, 1'b1, 1'b0, 1, 1'b0);
    // Poll: three busy reads then ready -> 35 + 3*33.
    rd_vals.push_back(8'h80);
    rd_vals.push_back(8'h8A);
    rd_vals.push_back(8'hFF);
    rd_vals.push_back(8'h07);
    run_read(2'd2, 1'b0, 134, 8'h07, 1'b0, 1'b0, 4, 1'b0);
    // Poll that is ready on the first read.
    rd_vals.push_back(8'h12);
    run_read(2'd2, 1'b0, 35, 8'h12, 1'b0, 1'b0, 1, 1'b0);
    // Poll with BF stuck at 1: POLL_MAX=4 reads then timeout.
    stuck_val = 8'h9C;
    run_read(2'd2, 1'b0, 134, 8'h9C, 1'b1, 1'b1, 4, 1'b0);
    stuck_val = 8'h00;
    // Grant arrives 10 cycles after bus_req.
    rd_vals.push_back(8'h33);
    run_read(2'd0, 1'b0, 45, 8'h33, 1'b0, 1'b0, 1, 1'b1);

    // Reset in the middle of EN high: aborted request yields no response.
    @(negedge clk);
    en_pulses = 0;
    exp_rs    = 1'b0;
    rd_vals.push_back(8'h55);
    req_valid = 1'b1;
    req_kind  = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (lcd_en) break;
      @(negedge clk);
    end
    chk("en_reached_before_reset", lcd_en, 1);
    repeat (5) @(negedge clk);
    en_skip = 1'b1;
    seen0 = resp_seen;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_lcd_en", lcd_en, 0);
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 0);
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", req_ready, 1);
    repeat (50) @(negedge clk);
    chk("midrst_no_resp", resp_seen, seen0);
    chk("midrst_idle_ctl", {bus_req, lcd_rs, lcd_rw, lcd_en}, 4'b0000);
    en_skip = 1'b0;
    rd_vals.delete();

    // A normal read still works after the abort.
    rd_vals.push_back(8'h6E);
    run_read(2'd1, 1'b1, 35, 8'h6E, 1'b0, 1'b0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
